proc_ctrl_seq: RTL and testbench

- Control sequencer for the 8-bit-opcode / 8-bit-address accumulator processor.
- Runs a fetch/decode/execute state machine that issues one-hot control strobes to the PC, MAR, IR, accumulator/ALU and memory interface.
- Handshakes with memory through mem_ready and sits between the instruction register and the datapath registers.

---
 rtl/proc_ctrl_seq.sv | 178 +++++++++++++++++
 tb/tb_proc_ctrl_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : proc_ctrl_seq
//  Brief    : Fetch/decode/execute control sequencer for the 8-bit accumulator
//             processor. Moore FSM issuing one-hot datapath/memory strobes.
//             Optional macro PROC_CTRL_ILLEGAL_TRAP_EN traps undefined opcodes
//             into HALT and flags them on illegal_op.
//  Revision : 1.0 - initial release
// ============================================================================
module proc_ctrl_seq #(
    parameter int OP   = 8,
    parameter int ADDR = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [OP-1:0] opcode,
    input  logic          acc_zero,
    input  logic          mem_ready,
    output logic          pc_out_en,
    output logic          ir_addr_out_en,
    output logic          mar_load,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          ir_load,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          acc_load,
    output logic          acc_src_alu,
    output logic          alu_sub,
    output logic          halted,
    output logic [3:0]    state
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic          illegal_op
`endif
);

    // Opcode map assumes at least 8 opcode bits so 0xFF is representable.
    generate
        if (OP < 8 || ADDR < 1) begin : g_param_check
            $error("proc_ctrl_seq: OP must be >= 8 and ADDR >= 1");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_F_ADDR = 4'd1,
        S_F_MEM  = 4'd2,
        S_F_IR   = 4'd3,
        S_DECODE = 4'd4,
        S_X_ADDR = 4'd5,
        S_X_RD   = 4'd6,
        S_X_WB   = 4'd7,
        S_X_WR   = 4'd8,
        S_X_JMP  = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [OP-1:0] c_OP_NOP = OP'(8'h00);
    localparam logic [OP-1:0] c_OP_LDA = OP'(8'h01);
    localparam logic [OP-1:0] c_OP_STA = OP'(8'h02);
    localparam logic [OP-1:0] c_OP_ADD = OP'(8'h03);
    localparam logic [OP-1:0] c_OP_SUB = OP'(8'h04);
    localparam logic [OP-1:0] c_OP_JMP = OP'(8'h05);
    localparam logic [OP-1:0] c_OP_JZ  = OP'(8'h06);
    localparam logic [OP-1:0] c_OP_HLT = OP'(8'hFF);

    localparam logic [1:0] c_CLS_LDA = 2'd0;
    localparam logic [1:0] c_CLS_ADD = 2'd1;
    localparam logic [1:0] c_CLS_SUB = 2'd2;
    localparam logic [1:0] c_CLS_STA = 2'd3;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cls;
    logic [1:0] w_cls_next;
    logic       w_illegal_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RESET;
            r_cls   <= c_CLS_LDA;
        end else begin
            r_state <= w_next;
            r_cls   <= w_cls_next;
        end
    end

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_illegal_set) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;
`endif

    // Next-state logic; the operand class latched in DECODE steers X_ADDR/X_WB.
    always_comb begin
        w_next        = r_state;
        w_cls_next    = r_cls;
        w_illegal_set = 1'b0;
        case (r_state)
            S_RESET:  w_next = S_F_ADDR;
            S_F_ADDR: w_next = S_F_MEM;
            S_F_MEM:  if (mem_ready) w_next = S_F_IR;
            S_F_IR:   w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_OP_NOP: w_next = S_F_ADDR;
                    c_OP_LDA: begin w_next = S_X_ADDR; w_cls_next = c_CLS_LDA; end
                    c_OP_STA: begin w_next = S_X_ADDR; w_cls_next = c_CLS_STA; end
                    c_OP_ADD: begin w_next = S_X_ADDR; w_cls_next = c_CLS_ADD; end
                    c_OP_SUB: begin w_next = S_X_ADDR; w_cls_next = c_CLS_SUB; end
                    c_OP_JMP: w_next = S_X_JMP;
                    c_OP_JZ:  w_next = acc_zero ? S_X_JMP : S_F_ADDR;
                    c_OP_HLT: w_next = S_HALT;
                    default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                        w_next        = S_HALT;
                        w_illegal_set = 1'b1;
`else
                        w_next        = S_F_ADDR;
`endif
                    end
                endcase
            end
            S_X_ADDR: w_next = (r_cls == c_CLS_STA) ? S_X_WR : S_X_RD;
            S_X_RD:   if (mem_ready) w_next = S_X_WB;
            S_X_WB:   w_next = S_F_ADDR;
            S_X_WR:   if (mem_ready) w_next = S_F_ADDR;
            S_X_JMP:  w_next = S_F_ADDR;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_RESET;
        endcase
    end

    // Moore outputs: decoded from the state register only.
    always_comb begin
        pc_out_en      = 1'b0;
        ir_addr_out_en = 1'b0;
        mar_load       = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        ir_load        = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        acc_load       = 1'b0;
        acc_src_alu    = 1'b0;
        alu_sub        = 1'b0;
        halted         = 1'b0;
        case (r_state)
            S_F_ADDR: begin pc_out_en = 1'b1; mar_load = 1'b1; end
            S_F_MEM:  mem_rd = 1'b1;
            S_F_IR:   begin ir_load = 1'b1; pc_inc = 1'b1; end
            S_X_ADDR: begin ir_addr_out_en = 1'b1; mar_load = 1'b1; end
            S_X_RD:   mem_rd = 1'b1;
            S_X_WB: begin
                acc_load    = 1'b1;
                acc_src_alu = (r_cls != c_CLS_LDA);
                alu_sub     = (r_cls == c_CLS_SUB);
            end
            S_X_WR:   mem_wr = 1'b1;
            S_X_JMP:  begin ir_addr_out_en = 1'b1; pc_load = 1'b1; end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_ctrl_seq
//  Brief    : Self-checking bench for proc_ctrl_seq: instruction table with a
//             scoreboard of per-instruction expectations, plus reset/halt cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] opcode;
    logic       acc_zero;
    logic       mem_ready;
    logic       pc_out_en, ir_addr_out_en, mar_load, mem_rd, mem_wr, ir_load;
    logic       pc_inc, pc_load, acc_load, acc_src_alu, alu_sub, halted;
    logic [3:0] state;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    proc_ctrl_seq #(.OP(8), .ADDR(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .acc_zero       (acc_zero),
        .mem_ready      (mem_ready),
        .pc_out_en      (pc_out_en),
        .ir_addr_out_en (ir_addr_out_en),
        .mar_load       (mar_load),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .ir_load        (ir_load),
        .pc_inc         (pc_inc),
        .pc_load        (pc_load),
        .acc_load       (acc_load),
        .acc_src_alu    (acc_src_alu),
        .alu_sub        (alu_sub),
        .halted         (halted),
        .state          (state)
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op     (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    logic [11:0] w_strobes;
    assign w_strobes = {pc_out_en, ir_addr_out_en, mar_load, mem_rd, mem_wr, ir_load,
                        pc_inc, pc_load, acc_load, acc_src_alu, alu_sub, halted};

    // One instruction: stimulus plus expected cycle count and strobe-cycle counts.
    typedef struct {
        logic [7:0] op;
        logic       az;
        int         fw;
        int         dw;
        int         cyc;
        int         rd;
        int         wr;
        int         accld;
        int         src;
        int         sub;
        int         pcld;
        int         iraddr;
        int         inc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fcnt   = 0;
    int   dcnt   = 0;

    function automatic vec_t mk(input logic [7:0] op, input logic az, input int fw,
                                input int dw, input int cyc, input int rd, input int wr,
                                input int accld, input int src, input int sub,
                                input int pcld, input int iraddr);
        vec_t v;
        v.op = op; v.az = az; v.fw = fw; v.dw = dw; v.cyc = cyc; v.rd = rd; v.wr = wr;
        v.accld = accld; v.src = src; v.sub = sub; v.pcld = pcld; v.iraddr = iraddr;
        v.inc = 1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory model: holds mem_ready low for the programmed wait count in each
    // memory state; outside memory states it is random and must be ignored.
    task automatic drive_mem();
        if (state == 4'd2) begin
            if (fcnt > 0) begin mem_ready = 1'b0; fcnt--; end
            else mem_ready = 1'b1;
        end else if (state == 4'd6 || state == 4'd8) begin
            if (dcnt > 0) begin mem_ready = 1'b0; dcnt--; end
            else mem_ready = 1'b1;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_inv();
        chk("inv_rd_wr", 32'(mem_rd & mem_wr), 0);
        chk("inv_pcout_iraddr", 32'(pc_out_en & ir_addr_out_en), 0);
        chk("inv_inc_load", 32'(pc_inc & pc_load), 0);
    endtask

    // Entered at a negedge with state == F_ADDR; returns at the next F_ADDR.
    task automatic run_instr(input vec_t v);
        vec_t e;
        int   cyc, rd, wr, al, src, sb, pl, ia, inc;
        bit   done;
        opcode   = v.op;
        acc_zero = v.az;
        fcnt     = v.fw;
        dcnt     = v.dw;
        exp_q.push_back(v);
        cyc = 0; rd = 0; wr = 0; al = 0; src = 0; sb = 0; pl = 0; ia = 0; inc = 0;
        done = 1'b0;
        while (!done) begin
            cyc++;
            rd  += int'(mem_rd);
            wr  += int'(mem_wr);
            al  += int'(acc_load);
            src += int'(acc_src_alu);
            sb  += int'(alu_sub);
            pl  += int'(pc_load);
            ia  += int'(ir_addr_out_en);
            inc += int'(pc_inc);
            check_inv();
            drive_mem();
            step();
            if (state == 4'd1) begin
                done = 1'b1;
            end else if (cyc >= 40) begin
                chk("instr_timeout", 32'(state), 1);
                done = 1'b1;
            end
        end
        e = exp_q.pop_front();
        chk($sformatf("op%02h_cycles", e.op), cyc, e.cyc);
        chk($sformatf("op%02h_mem_rd", e.op), rd, e.rd);
        chk($sformatf("op%02h_mem_wr", e.op), wr, e.wr);
        chk($sformatf("op%02h_acc_load", e.op), al, e.accld);
        chk($sformatf("op%02h_acc_src_alu", e.op), src, e.src);
        chk($sformatf("op%02h_alu_sub", e.op), sb, e.sub);
        chk($sformatf("op%02h_pc_load", e.op), pl, e.pcld);
        chk($sformatf("op%02h_ir_addr_out_en", e.op), ia, e.iraddr);
        chk($sformatf("op%02h_pc_inc", e.op), inc, e.inc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        //              op     az  fw dw cyc rd wr al src sub pl ia
        vecs.push_back(mk(8'h00, 0, 0, 0,  4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0,  4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'h01, 0, 0, 3, 10, 5, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h04, 0, 0, 0,  7, 2, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(8'h02, 0, 0, 0,  6, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(8'h03, 1, 0, 0,  7, 2, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(8'h02, 0, 0, 2,  8, 1, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(8'h05, 0, 0, 0,  5, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(8'h06, 1, 0, 0,  5, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(8'h06, 0, 0, 0,  4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'h00, 0, 2, 0,  6, 3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'h01, 1, 1, 1,  9, 4, 0, 1, 0, 0, 0, 1));
`ifndef PROC_CTRL_ILLEGAL_TRAP_EN
        vecs.push_back(mk(8'h42, 0, 0, 0,  4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'hFE, 1, 0, 0,  4, 1, 0, 0, 0, 0, 0, 0));
`endif

        rst = 1'b1; opcode = 8'h00; acc_zero = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(state), 0);
        chk("reset_strobes", 32'(w_strobes), 0);
        rst = 1'b0;
        step();
        chk("post_reset_state", 32'(state), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_instr(vecs[i]);
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        // Reset asserted for two cycles while a read is stalled in X_RD.
        opcode = 8'h01; fcnt = 0; dcnt = 100;
        n = 0;
        while (state != 4'd6 && n < 10) begin drive_mem(); step(); n++; end
        chk("xrd_reached", 32'(state), 6);
        chk("xrd_mem_rd", 32'(mem_rd), 1);
        rst = 1'b1;
        drive_mem();
        step();
        chk("rst_mid_xrd_state", 32'(state), 0);
        chk("rst_mid_xrd_strobes", 32'(w_strobes), 0);
        step();
        chk("rst_hold_state", 32'(state), 0);
        rst = 1'b0; dcnt = 0;
        step();
        chk("rst_release_state", 32'(state), 1);

        // HLT: halted after 4 cycles, then held with no strobes.
        opcode = 8'hFF; n = 0;
        while (!halted && n < 20) begin drive_mem(); step(); n++; end
        chk("hlt_latency", n, 4);
        for (int i = 0; i < 20; i++) begin
            opcode   = 8'($urandom_range(0, 255));
            acc_zero = 1'($urandom_range(0, 1));
            drive_mem();
            step();
            chk("halt_state", 32'(state), 10);
            chk("halt_strobes", 32'(w_strobes), 1);
        end
        rst = 1'b1; step();
        rst = 1'b0; step();
        chk("halt_exit_state", 32'(state), 1);

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        opcode = 8'h42; n = 0;
        chk("illegal_clear", 32'(illegal_op), 0);
        while (!halted && n < 20) begin drive_mem(); step(); n++; end
        chk("illegal_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            opcode = 8'h00;
            drive_mem();
            step();
            chk("illegal_held", 32'(illegal_op), 1);
            chk("illegal_halt_strobes", 32'(w_strobes), 1);
        end
        rst = 1'b1; step();
        chk("illegal_reset", 32'(illegal_op), 0);
        chk("illegal_reset_state", 32'(state), 0);
        rst = 1'b0; step();
        chk("illegal_exit_state", 32'(state), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
